// File: rtl/snn_fixed_pkg.sv
// Shared fixed-point constants and FSM state type for the neuron integrator.
package snn_fixed_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 8;

  localparam logic [WORD_W-1:0] ONE     = 32'h00010000;
  localparam logic [WORD_W-1:0] ZERO    = 32'h00000000;
  localparam logic [WORD_W-2:0] MAG_MAX = 31'h7FFFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/neuron_state_integrator_if.sv
// Sample-in / result-out handshake bundle for the neuron state integrator.
interface neuron_state_integrator_if #(
  parameter int unsigned N = 32
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dv;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] v_out;
  logic         spike;

  modport master (
    output in_valid, dv, out_ready,
    input  in_ready, out_valid, v_out, spike
  );

  modport slave (
    input  in_valid, dv, out_ready,
    output in_ready, out_valid, v_out, spike
  );

endinterface

// File: rtl/sm_add_sat.sv
// Combinational sign-magnitude adder; wraps or clamps the magnitude on overflow.
module sm_add_sat #(
  parameter int unsigned N   = 32,
  parameter bit          SAT = 1'b0
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         ovf
);

  localparam int unsigned MW = N - 1;

  logic          a_sign;
  logic          b_sign;
  logic [MW-1:0] a_mag;
  logic [MW-1:0] b_mag;
  logic [MW:0]   mag_add;
  logic [MW-1:0] mag_res;
  logic          sign_res;

  // Add magnitudes on matching signs, otherwise subtract smaller from larger.
  always_comb begin
    a_sign   = a[N-1];
    b_sign   = b[N-1];
    a_mag    = a[MW-1:0];
    b_mag    = b[MW-1:0];
    mag_add  = {1'b0, a_mag} + {1'b0, b_mag};
    ovf      = 1'b0;
    sign_res = a_sign;
    mag_res  = '0;
    if (a_sign == b_sign) begin
      ovf      = mag_add[MW];
      sign_res = a_sign;
      if (SAT && mag_add[MW]) begin
        mag_res = '1;
      end else begin
        mag_res = mag_add[MW-1:0];
      end
    end else if (a_mag >= b_mag) begin
      mag_res  = a_mag - b_mag;
      sign_res = a_sign;
    end else begin
      mag_res  = b_mag - a_mag;
      sign_res = b_sign;
    end
    // A zero result is always reported as +0.
    if (mag_res == '0) begin
      sign_res = 1'b0;
    end
    sum = {sign_res, mag_res};
  end

endmodule

// File: rtl/neuron_state_integrator.sv
// Forward-Euler membrane integrator: v += dv*DT, spike and reset at threshold,
// followed by a refractory hold of REFRAC_SAMPLES samples.
// Define NEURON_INTEGRATOR_SATURATE_EN to clamp the voltage magnitude on
// overflow; by default the magnitude wraps modulo 2^(N-1).
module neuron_state_integrator
  import snn_fixed_pkg::*;
#(
  parameter int unsigned  N              = 32,
  parameter int unsigned  Q              = 16,
  parameter logic [N-1:0] DT             = N'(32'h00002000),
  parameter logic [N-1:0] V_TH           = N'(ONE),
  parameter logic [N-1:0] V_RESET        = N'(ZERO),
  parameter logic [N-1:0] V_INIT         = N'(ZERO),
  parameter int unsigned  REFRAC_SAMPLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  neuron_state_integrator_if.slave  bus
);

  localparam int unsigned MW = N - 1;
  localparam int unsigned PW = 2 * MW;

`ifdef NEURON_INTEGRATOR_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_t           state_q;
  state_t           state_d;
  logic             in_ready_q;
  logic             in_ready_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic [N-1:0]     dv_q;
  logic [N-1:0]     dv_d;
  logic [N-1:0]     p_q;
  logic [N-1:0]     p_d;
  logic [N-1:0]     v_q;
  logic [N-1:0]     v_d;
  logic             spike_q;
  logic             spike_d;
  logic [CNT_W-1:0] refrac_q;
  logic [CNT_W-1:0] refrac_d;

  logic [PW-1:0]    prod_full;
  logic [MW-1:0]    p_mag;
  logic [N-1:0]     add_sum;
  logic             unused_add_ovf;
  logic             v_ge_th;

  // Sign-magnitude word mapped onto a two's-complement value one bit wider.
  function automatic logic signed [N:0] sm_to_tc(input logic [N-1:0] x);
    logic signed [N:0] m;
    m = $signed({2'b00, x[N-2:0]});
    return x[N-1] ? -m : m;
  endfunction

  // Magnitude product rescaled back to Q fraction bits (truncating).
  always_comb begin
    prod_full = PW'(dv_q[MW-1:0]) * PW'(DT[MW-1:0]);
    p_mag     = MW'(prod_full >> Q);
  end

  sm_add_sat #(
    .N   (N),
    .SAT (SAT_EN)
  ) u_add (
    .a   (v_q),
    .b   (p_q),
    .sum (add_sum),
    .ovf (unused_add_ovf)
  );

  // Threshold test is a signed comparison of the candidate voltage.
  always_comb begin
    v_ge_th = (sm_to_tc(add_sum) >= sm_to_tc(V_TH));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dv_q        <= '0;
      p_q         <= '0;
      v_q         <= V_INIT;
      spike_q     <= 1'b0;
      refrac_q    <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dv_q        <= dv_d;
      p_q         <= p_d;
      v_q         <= v_d;
      spike_q     <= spike_d;
      refrac_q    <= refrac_d;
    end
  end

  // Next-state, datapath updates and registered handshake decode.
  always_comb begin
    state_d  = state_q;
    dv_d     = dv_q;
    p_d      = p_q;
    v_d      = v_q;
    spike_d  = spike_q;
    refrac_d = refrac_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dv_d    = bus.dv;
          state_d = MUL;
        end
      end
      MUL: begin
        p_d     = {dv_q[N-1] ^ DT[N-1], p_mag};
        state_d = ADD;
      end
      ADD: begin
        if (refrac_q != '0) begin
          refrac_d = refrac_q - CNT_W'(1);
          spike_d  = 1'b0;
        end else if (v_ge_th) begin
          v_d      = V_RESET;
          spike_d  = 1'b1;
          refrac_d = CNT_W'(REFRAC_SAMPLES);
        end else begin
          v_d      = add_sum;
          spike_d  = 1'b0;
        end
        state_d = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == OUT);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.v_out     = v_q;
  assign bus.spike     = spike_q;

endmodule

// File: tb/tb_neuron_state_integrator.sv
// Bench for neuron_state_integrator: directed vector table, reset and overflow
// sequences, then randomized samples against an integer reference model.
module tb_neuron_state_integrator;
  import snn_fixed_pkg::*;

`ifdef NEURON_INTEGRATOR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // Reference model constants for the default-parameter instance.
  localparam longint M_TH     = 64'h10000;
  localparam longint M_RST    = 0;
  localparam int     M_REFRAC = 2;
  localparam longint M_DT     = 64'h2000;
  localparam longint M_SCALE  = 64'h10000;
  localparam longint M_MAGMAX = longint'(MAG_MAX);

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  neuron_state_integrator_if #(.N(32)) bif ();
  neuron_state_integrator_if #(.N(32)) bif2 ();

  neuron_state_integrator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  // Instance starting near full scale; V_RESET equals the clamp value so a
  // saturated spike reports 7FFFFFFF.
  neuron_state_integrator #(
    .V_INIT  (32'h7FFF0000),
    .V_TH    (32'h7FFFFFFF),
    .V_RESET (32'h7FFFFFFF)
  ) dut_ovf (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  longint m_v;
  int     m_cnt;

  // Behavioural model: plain signed arithmetic on the numeric voltage.
  task automatic model_step(input logic [31:0] d, output logic [31:0] ev, output logic es);
    longint p;
    longint s;
    longint mag;
    p = (longint'(d[30:0]) * M_DT) / M_SCALE;
    if (d[31]) p = -p;
    es = 1'b0;
    if (m_cnt > 0) begin
      m_cnt--;
    end else begin
      s   = m_v + p;
      mag = (s < 0) ? -s : s;
      if (mag > M_MAGMAX) mag = SAT ? M_MAGMAX : (mag % (M_MAGMAX + 1));
      s = (s < 0) ? -mag : mag;
      if (s >= M_TH) begin
        es    = 1'b1;
        m_v   = M_RST;
        m_cnt = M_REFRAC;
      end else begin
        m_v = s;
      end
    end
    ev = (m_v < 0) ? {1'b1, 31'(-m_v)} : {1'b0, 31'(m_v)};
  endtask

  // One full transaction on the main instance, with optional output stall and
  // an optional new sample presented while stalled.
  task automatic do_sample(input logic [31:0] d, input int stall, input bit pend,
                           input logic [31:0] pend_dv,
                           output logic [31:0] gv, output logic gs);
    int n;
    logic [31:0] hv;
    logic hs;
    gv = '0;
    gs = 1'b0;
    bif.dv        = d;
    bif.in_valid  = 1'b1;
    bif.out_ready = 1'b0;
    n = 0;
    while (!bif.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bif.in_ready) begin
      check("accept_timeout", 32'(bif.in_ready), 32'd1);
      bif.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bif.in_valid = 1'b0;
    bif.dv       = $urandom();
    check("busy_in_ready", 32'(bif.in_ready), 32'd0);
    n = 0;
    while (!bif.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'd2);
    hv = bif.v_out;
    hs = bif.spike;
    if (pend) begin
      bif.in_valid = 1'b1;
      bif.dv       = pend_dv;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(bif.out_valid), 32'd1);
      check("stall_in_ready", 32'(bif.in_ready), 32'd0);
      check("stall_v_out", bif.v_out, hv);
      check("stall_spike", 32'(bif.spike), 32'(hs));
    end
    bif.out_ready = 1'b1;
    gv = bif.v_out;
    gs = bif.spike;
    @(negedge clk);
    bif.out_ready = 1'b0;
    check("release_idle", {30'd0, bif.in_ready, bif.out_valid}, 32'd2);
  endtask

  typedef struct {
    logic [31:0] dv;
    int          stall;
    bit          pend;
    logic [31:0] ev;
    logic        es;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] gv;
    logic        gs;
    logic [31:0] ev;
    logic        es;
    logic [31:0] d;
    logic [31:0] nd;
    int          n;

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bif.in_valid   = 1'b0;
    bif.dv         = '0;
    bif.out_ready  = 1'b0;
    bif2.in_valid  = 1'b0;
    bif2.dv        = '0;
    bif2.out_ready = 1'b0;

    // Directed sequence: accumulation, spike, refractory hold, sign handling.
    vecs[0] = '{32'h00020000, 0, 1'b0, 32'h00004000, 1'b0};
    vecs[1] = '{32'h00020000, 5, 1'b1, 32'h00008000, 1'b0};
    vecs[2] = '{32'h00020000, 0, 1'b0, 32'h0000C000, 1'b0};
    vecs[3] = '{32'h00020000, 1, 1'b0, 32'h00000000, 1'b1};
    vecs[4] = '{32'h00020000, 0, 1'b0, 32'h00000000, 1'b0};
    vecs[5] = '{32'h00020000, 2, 1'b0, 32'h00000000, 1'b0};
    vecs[6] = '{32'h00020000, 0, 1'b0, 32'h00004000, 1'b0};
    vecs[7] = '{32'h80020000, 0, 1'b0, 32'h00000000, 1'b0};
    vecs[8] = '{32'h80010000, 0, 1'b0, 32'h80002000, 1'b0};
    vecs[9] = '{32'h00010000, 0, 1'b1, 32'h00000000, 1'b0};

    #12;
    check("rst_in_ready", 32'(bif.in_ready), 32'd1);
    check("rst_out_valid", 32'(bif.out_valid), 32'd0);
    check("rst_v_out", bif.v_out, 32'h00000000);
    check("rst_spike", 32'(bif.spike), 32'd0);
    check("rst_ovf_v_out", bif2.v_out, 32'h7FFF0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      nd = (i < 9) ? vecs[i+1].dv : 32'h00000000;
      do_sample(vecs[i].dv, vecs[i].stall, vecs[i].pend, nd, gv, gs);
      check($sformatf("vec%0d_v", i), gv, vecs[i].ev);
      check($sformatf("vec%0d_spike", i), 32'(gs), 32'(vecs[i].es));
    end

    // Reset in the middle of MUL discards the sample and restores V_INIT.
    do_sample(32'h00020000, 0, 1'b0, 32'h0, gv, gs);
    check("pre_rst_v", gv, 32'h00004000);
    bif.dv       = 32'h00020000;
    bif.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    check("mul_in_ready", 32'(bif.in_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bif.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bif.out_valid), 32'd0);
    check("midrst_v_out", bif.v_out, 32'h00000000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_sample(32'h00020000, 0, 1'b0, 32'h0, gv, gs);
    check("post_rst_v", gv, 32'h00004000);
    check("post_rst_spike", 32'(gs), 32'd0);

    // Overflow on the near-full-scale instance: 7FFF0000 + 0FFFFFFF.
    bif2.dv        = 32'h7FFFFFFF;
    bif2.in_valid  = 1'b1;
    bif2.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bif2.in_valid = 1'b0;
    n = 0;
    while (!bif2.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ovf_latency", 32'(n), 32'd2);
`ifdef NEURON_INTEGRATOR_SATURATE_EN
    check("ovf_v_out", bif2.v_out, 32'h7FFFFFFF);
    check("ovf_spike", 32'(bif2.spike), 32'd1);
`else
    check("ovf_v_out", bif2.v_out, 32'h0FFEFFFF);
    check("ovf_spike", 32'(bif2.spike), 32'd0);
`endif
    bif2.out_ready = 1'b1;
    @(negedge clk);
    bif2.out_ready = 1'b0;

    // Randomized samples; v is 0x4000 with no refractory count at this point.
    m_v   = 64'h4000;
    m_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      d = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h00030000))};
      model_step(d, ev, es);
      do_sample(d, int'($urandom_range(0, 2)), 1'b0, 32'h0, gv, gs);
      check("rand_v", gv, ev);
      check("rand_spike", 32'(gs), 32'(es));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_state_integrator.md
NEURON_STATE_INTEGRATOR -- requirements
Module: neuron_state_integrator

Interface
REQ-001 Parameter N, 32: total word width, sign-magnitude (bit N-1 = sign).
REQ-002 Parameter Q, 16: fraction bits.
REQ-003 Parameter DT, 32'h00002000: Euler step (0.125), sign-magnitude QN.Q.
REQ-004 Parameter V_TH, 32'h00010000: spike threshold (1.0).
REQ-005 Parameter V_RESET, 32'h00000000: post-spike voltage.
REQ-006 Parameter V_INIT, 32'h00000000: voltage after reset.
REQ-007 Parameter REFRAC_SAMPLES, 2: samples held after a spike; range 0..255.
REQ-008 clk  input  1  sole clock; all state updates on its rising edge.
REQ-009 rst_n  input  1  reset; asynchronous, active-low.
REQ-010 in_valid  input  1  dv sample present.
REQ-011 in_ready  output  1  block can accept dv.
REQ-012 dv  input  N  derivative dV/dt from the upstream equation datapath, sign-magnitude.
REQ-013 out_valid  output  1  v_out/spike valid.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 v_out  output  N  updated membrane voltage.
REQ-016 spike  output  1  this result crossed threshold.

Function
REQ-017 FSM states IDLE, MUL, ADD, OUT; in_ready = (state == IDLE); out_valid = (state == OUT).
REQ-018 IDLE -> MUL on the edge where in_valid && in_ready; dv is registered at that edge.
REQ-019 MUL -> ADD unconditionally; product p = dv*DT is registered: sign = XOR of signs, magnitude = (|dv|*|DT|)[N-2+Q:Q].
REQ-020 ADD -> OUT unconditionally; the v register, spike register and refractory counter update at this edge.
REQ-021 OUT -> IDLE on the edge where out_ready = 1; otherwise stay in OUT with v_out and spike held stable.
REQ-022 Latency: out_valid rises two edges after the accepting edge; peak throughput is one sample per 4 cycles.
REQ-023 In ADD with the refractory counter > 0: v is unchanged, spike = 0, counter decrements by 1.
REQ-024 In ADD with the counter = 0: v_next = v + p, using a sign-magnitude add that subtracts magnitudes on sign mismatch.
REQ-025 A zero-magnitude sum is +0 (sign 0); -0 is never produced.
REQ-026 Spike is asserted when v_next is signed-compared >= V_TH; v then loads V_RESET, the counter loads REFRAC_SAMPLES, and v_out reports V_RESET.
REQ-027 Without a spike, v loads v_next and spike = 0.
REQ-028 Magnitude overflow handling follows REQ-033.
REQ-029 in_valid while not in IDLE has no effect; dv is sampled only at the accepting edge.

Reset
REQ-030 Assertion of rst_n at any time, including mid-operation, immediately forces:
- state = IDLE, hence in_ready = 1 and out_valid = 0
- v = V_INIT, spike = 0, refractory counter = 0, dv/product registers = 0
REQ-031 Any in-flight sample is discarded; on release, the first accepting edge starts normally.

Configuration
REQ-032 Macro NEURON_INTEGRATOR_SATURATE_EN selects the overflow behaviour.
REQ-033 Defined: an overflowing add clamps the magnitude to all-ones (N-1 bits) and keeps the sign. Undefined: the magnitude wraps modulo 2^(N-1) and keeps the sign.

Structure
REQ-034 Package snn_fixed_pkg holds:
- the FSM state enum
- the constants ONE (32'h00010000), ZERO, MAG_MAX (31'h7FFFFFFF)
REQ-035 Sub-module sm_add_sat: a combinational sign-magnitude adder with overflow flag and optional saturation; instantiated once for v + p.

Verification
REQ-036 rst_n low mid-MUL -> the same cycle shows in_ready = 1, out_valid = 0; v = 0 after release.
REQ-037 dv = 32'h00020000, out_ready = 1:
- out_valid rises two edges after the accept
- v_out = 32'h00004000, spike = 0
REQ-038 Four samples of dv = 32'h00020000:
- the 4th gives spike = 1, v_out = 32'h00000000
- the next 2 samples give v_out = 0, spike = 0
- the 7th sample gives 32'h00004000
REQ-039 Sign handling:
- dv = 32'h80010000 from v = 0 -> v_out = 32'h80002000
- then dv = 32'h00010000 -> v_out = 32'h00000000 (no -0)
REQ-040 Overflow: V_INIT = 32'h7FFF0000, V_TH = 32'h7FFFFFFF, dv = 32'h7FFFFFFF:
- with the macro defined -> v_out = 32'h7FFFFFFF, spike = 1
- without the macro -> wrapped magnitude, spike = 0
REQ-041 Back-pressure: out_ready held low for 5 cycles in OUT:
- out_valid, v_out and spike stay stable
- in_ready = 0
- the sample presented during the stall is accepted only after the OUT->IDLE edge
